// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for the fabric configuration chain. Serialises words MSB-first
// onto ccff_head with a matching prog_clk enable, and runs a one-hot chain test.
module ccff_bitstream_loader #(
  parameter int BITSTREAM_SIZE = 29696,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_W          = $clog2(BITSTREAM_SIZE + 4)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  prog_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [CNT_W-1:0]      shift_count
);

  localparam int N_WORDS   = (BITSTREAM_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = ((BITSTREAM_SIZE % WORD_WIDTH) == 0) ? WORD_WIDTH
                                                                  : (BITSTREAM_SIZE % WORD_WIDTH);
  localparam int BCNT_W    = $clog2(WORD_WIDTH + 1);
  localparam int WCNT_W    = $clog2(N_WORDS + 1);

  localparam logic [BCNT_W-1:0] FULL_CNT   = BCNT_W'(WORD_WIDTH);
  localparam logic [BCNT_W-1:0] LAST_CNT   = BCNT_W'(LAST_BITS);
  localparam logic [WCNT_W-1:0] WORDS_MAX  = WCNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0]  PROG_LAST  = CNT_W'(BITSTREAM_SIZE - 1);
  localparam logic [CNT_W-1:0]  TEST_MARK  = CNT_W'(BITSTREAM_SIZE);
  localparam logic [CNT_W-1:0]  TEST_ZERO1 = CNT_W'(BITSTREAM_SIZE + 1);
  localparam logic [CNT_W-1:0]  TEST_LAST  = CNT_W'(BITSTREAM_SIZE + 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROG   = 3'd1,
    ST_TEST   = 3'd2,
    ST_DONE   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t                state_r;
  logic [WORD_WIDTH-1:0] buf_r;
  logic [BCNT_W-1:0]     buf_cnt_r;
  logic [WCNT_W-1:0]     words_r;
  logic                  err_r;

  logic                  accept_s;
  logic                  issue_s;
  logic [BCNT_W-1:0]     load_cnt_s;
  logic                  tail_bad_s;
  logic                  err_next_s;

  assign word_ready = (state_r == ST_PROG) && (words_r < WORDS_MAX) && (buf_cnt_r <= BCNT_W'(1));

  // Handshake, buffer and chain-test sampling decisions for the current cycle
  always_comb begin
    accept_s   = word_valid && word_ready;
    issue_s    = (buf_cnt_r != BCNT_W'(0));
    load_cnt_s = FULL_CNT;
    tail_bad_s = 1'b0;
    if (words_r == (WORDS_MAX - WCNT_W'(1))) begin
      load_cnt_s = LAST_CNT;
    end else begin
      load_cnt_s = FULL_CNT;
    end
    // The tail seen at the edge ending shift k reflects the chain after k shifts
    if (shift_count == TEST_MARK) begin
      tail_bad_s = !ccff_tail;
    end else if ((shift_count == TEST_ZERO1) || (shift_count == TEST_LAST)) begin
      tail_bad_s = ccff_tail;
    end else begin
      tail_bad_s = 1'b0;
    end
    err_next_s = err_r || tail_bad_s;
  end

  // Control FSM with all registered outputs
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      buf_cnt_r   <= '0;
      words_r     <= '0;
      err_r       <= 1'b0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      shift_count <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_RESULT: begin
          if (start) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            err_r       <= 1'b0;
            shift_count <= '0;
            buf_cnt_r   <= '0;
            words_r     <= '0;
            busy        <= 1'b1;
            if (mode) begin
              // The marker goes out on the very first test shift
              state_r     <= ST_TEST;
              prog_clk_en <= 1'b1;
              ccff_head   <= 1'b1;
            end else begin
              state_r     <= ST_PROG;
              prog_clk_en <= 1'b0;
              ccff_head   <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end

        ST_PROG: begin
          if (prog_clk_en && (shift_count == PROG_LAST)) begin
            shift_count <= shift_count + CNT_W'(1);
            prog_clk_en <= 1'b0;
            ccff_head   <= 1'b0;
            buf_cnt_r   <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            if (prog_clk_en) begin
              shift_count <= shift_count + CNT_W'(1);
            end else begin
              shift_count <= shift_count;
            end
            if (issue_s) begin
              ccff_head   <= buf_r[WORD_WIDTH-1];
              prog_clk_en <= 1'b1;
            end else begin
              prog_clk_en <= 1'b0;
            end
            // A load while one bit remains pops that bit at the same edge
            if (accept_s) begin
              buf_r     <= word_data;
              buf_cnt_r <= load_cnt_s;
              words_r   <= words_r + WCNT_W'(1);
            end else if (issue_s) begin
              buf_r     <= buf_r << 1;
              buf_cnt_r <= buf_cnt_r - BCNT_W'(1);
            end else begin
              buf_cnt_r <= buf_cnt_r;
            end
          end
        end

        ST_TEST: begin
          shift_count <= shift_count + CNT_W'(1);
          ccff_head   <= 1'b0;
          err_r       <= err_next_s;
          if (shift_count == TEST_LAST) begin
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            pass        <= !err_next_s;
            fail        <= err_next_s;
            state_r     <= ST_RESULT;
          end else begin
            prog_clk_en <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          prog_clk_en <= 1'b0;
          ccff_head   <= 1'b0;
          busy        <= 1'b0;
          buf_cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule
